memory_scrub_engine: RTL and testbench

- Responder for the recovery controller's memory-scrub request interface.
- Takes a level request with base address and byte size, then walks the region one memory word at a time over a simple read/write memory port.
- Writes corrected data back on ECC correctable errors (CE) and flags uncorrectable errors (UE).
- Returns a one-cycle done pulse with an error flag. Sits between the recovery controller and the memory/ECC datapath.

---
 rtl/memory_scrub_engine_pkg.sv | 29 ++
 rtl/memory_scrub_engine_if.sv | 25 ++
 rtl/memory_scrub_engine_sat_counter.sv | 22 ++
 rtl/memory_scrub_engine.sv | 178 +++++++++++++++++
 tb/tb_memory_scrub_engine.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_scrub_engine_pkg.sv
// Shared types and helpers for the memory scrub engine.
package mem_scrub_pkg;

  // Word count needs 34 bits: 32-bit size + sub-word offset + rounding term.
  localparam int unsigned WC_W = 34;

  // Default width of the saturating CE/UE statistic counters.
  localparam int unsigned SAT_CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    NEXT,
    DONE,
    RELEASE
  } scrub_state_t;

  // Number of memory words touched by [offset, offset+size), rounded up.
  function automatic logic [WC_W-1:0] word_count(input logic [31:0] offset,
                                                  input logic [31:0] size,
                                                  input int unsigned wb_log2);
    logic [WC_W-1:0] sum;
    sum = {2'b00, offset} + {2'b00, size} + ((WC_W'(1) << wb_log2) - WC_W'(1));
    return sum >> wb_log2;
  endfunction

endpackage

// File: rtl/memory_scrub_engine_if.sv
// Memory port between the scrub engine (master) and the memory/ECC datapath (slave).
interface memory_scrub_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata_corr;
  logic              mem_ecc_ce;
  logic              mem_ecc_ue;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata_corr, mem_ecc_ce, mem_ecc_ue
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata_corr, mem_ecc_ce, mem_ecc_ue
  );
endinterface

// File: rtl/memory_scrub_engine_sat_counter.sv
// Saturating event counter used for the CE and UE statistics.
module scrub_sat_counter
  import mem_scrub_pkg::*;
#(
  parameter int unsigned CNT_W = SAT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/memory_scrub_engine.sv
// Memory scrub engine: walks a byte region word by word, writes back
// ECC-corrected data on correctable errors and flags uncorrectable ones.
// Optional: define SCRUB_UE_ADDR_LOG_EN to log the address of the first UE.
module memory_scrub_engine
  import mem_scrub_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = SAT_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scrub_req,
  input  logic [ADDR_W-1:0]    scrub_addr,
  input  logic [31:0]          scrub_size,
  output logic                 scrub_done,
  output logic                 scrub_error,
  output logic                 scrub_busy,
  memory_scrub_engine_if.master mem,
  output logic [CNT_W-1:0]     ce_count,
  output logic [CNT_W-1:0]     ue_count,
  output logic [ADDR_W-1:0]    ue_first_addr
);

  localparam int unsigned WORD_BYTES = DATA_W / 8;
  localparam int unsigned WB_LOG2    = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

  scrub_state_t      state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [WC_W-1:0]   rem_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sticky_err;

  logic [31:0]       start_offset;
  logic [WC_W-1:0]   n_words;
  logic              req_c, we_c, done_c, ce_inc, ue_inc;

  assign start_offset = 32'(scrub_addr & OFF_MASK);
  assign n_words      = word_count(start_offset, scrub_size, WB_LOG2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    we_c    = 1'b0;
    done_c  = 1'b0;
    ce_inc  = 1'b0;
    ue_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (scrub_req) state_n = (n_words == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        req_c = 1'b1;
        // A grant already issued must be followed through; abort only if idle-waiting.
        if (mem.mem_gnt)     state_n = RD_WAIT;
        else if (!scrub_req) state_n = IDLE;
      end
      RD_WAIT: begin
        if (mem.mem_rvalid) begin
          if (mem.mem_ecc_ue) begin
            ue_inc  = 1'b1;
            state_n = NEXT;
          end else if (mem.mem_ecc_ce) begin
            ce_inc  = 1'b1;
            state_n = WR_REQ;
          end else begin
            state_n = NEXT;
          end
        end
      end
      WR_REQ: begin
        req_c = 1'b1;
        we_c  = 1'b1;
        if (mem.mem_gnt) state_n = NEXT;
      end
      NEXT: begin
        if (!scrub_req)              state_n = IDLE;
        else if (rem_q == WC_W'(1))  state_n = DONE;
        else                         state_n = RD_REQ;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: begin
        if (!scrub_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Region walk datapath: address, remaining words, write-back data, sticky UE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      sticky_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scrub_req) begin
            addr_q     <= scrub_addr & ~OFF_MASK;
            rem_q      <= n_words;
            sticky_err <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (ue_inc) sticky_err <= 1'b1;
          if (ce_inc) wdata_q    <= mem.mem_rdata_corr;
        end
        NEXT: begin
          if (scrub_req) begin
            rem_q  <= rem_q - WC_W'(1);
            addr_q <= addr_q + ADDR_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign scrub_done  = done_c;
  assign scrub_error = done_c & sticky_err;
  assign scrub_busy  = (state != IDLE);

  scrub_sat_counter #(.CNT_W(CNT_W)) u_ce_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ce_inc),
    .count (ce_count)
  );

  scrub_sat_counter #(.CNT_W(CNT_W)) u_ue_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ue_inc),
    .count (ue_count)
  );

`ifdef SCRUB_UE_ADDR_LOG_EN
  logic              ue_seen;
  logic [ADDR_W-1:0] ue_first_q;

  // Capture the address of the first UE since reset and hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ue_seen    <= 1'b0;
      ue_first_q <= '0;
    end else if (ue_inc && !ue_seen) begin
      ue_seen    <= 1'b1;
      ue_first_q <= addr_q;
    end
  end

  assign ue_first_addr = ue_first_q;
`else
  assign ue_first_addr = '0;
`endif

endmodule

// File: tb/tb_memory_scrub_engine.sv
// Directed bench for memory_scrub_engine with a memory model and an access scoreboard.
module tb_memory_scrub_engine;

  localparam logic [31:0] NONE = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        scrub_req;
  logic [31:0] scrub_addr;
  logic [31:0] scrub_size;
  logic        scrub_done, scrub_error, scrub_busy;
  logic [15:0] ce_count, ue_count;
  logic [31:0] ue_first_addr;

  memory_scrub_engine_if #(.ADDR_W(32), .DATA_W(64)) mem_bus ();

  memory_scrub_engine #(.ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .scrub_req     (scrub_req),
    .scrub_addr    (scrub_addr),
    .scrub_size    (scrub_size),
    .scrub_done    (scrub_done),
    .scrub_error   (scrub_error),
    .scrub_busy    (scrub_busy),
    .mem           (mem_bus),
    .ce_count      (ce_count),
    .ue_count      (ue_count),
    .ue_first_addr (ue_first_addr)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int unsigned gnt_delay, rd_lat, wait_cnt, rv_cnt;
  logic        rv_pending;
  logic [31:0] rv_addr;
  logic [31:0] ce_a0, ce_a1, ue_a0, ue_a1;

  function automatic bit ce_at(input logic [31:0] a);
    return (a == ce_a0) || (a == ce_a1);
  endfunction

  function automatic bit ue_at(input logic [31:0] a);
    return (a == ue_a0) || (a == ue_a1);
  endfunction

  function automatic logic [63:0] data_at(input logic [31:0] a);
    return {a, ~a};
  endfunction

  assign mem_bus.mem_gnt        = mem_bus.mem_req && (wait_cnt >= gnt_delay);
  assign mem_bus.mem_rvalid     = rv_pending && (rv_cnt == 0);
  assign mem_bus.mem_rdata_corr = data_at(rv_addr);
  assign mem_bus.mem_ecc_ce     = mem_bus.mem_rvalid && ce_at(rv_addr);
  assign mem_bus.mem_ecc_ue     = mem_bus.mem_rvalid && ue_at(rv_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 0;
      rv_cnt     <= 0;
      rv_pending <= 1'b0;
      rv_addr    <= '0;
    end else begin
      if (mem_bus.mem_req && !mem_bus.mem_gnt) wait_cnt <= wait_cnt + 1;
      else                                     wait_cnt <= 0;
      if (mem_bus.mem_req && mem_bus.mem_gnt && !mem_bus.mem_we) begin
        rv_pending <= 1'b1;
        rv_cnt     <= rd_lat - 1;
        rv_addr    <= mem_bus.mem_addr;
      end else if (rv_pending) begin
        if (rv_cnt == 0) rv_pending <= 1'b0;
        else             rv_cnt     <= rv_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
  } acc_t;

  acc_t exp_q[$];

  logic        stab_pending = 1'b0;
  logic        stab_we;
  logic [31:0] stab_addr;
  logic [63:0] stab_wdata;

  always @(negedge clk) begin
    if (rst) begin
      stab_pending = 1'b0;
    end else begin
      if (mem_bus.mem_req) begin
        if (stab_pending) begin
          chk("stable_addr", mem_bus.mem_addr, stab_addr);
          chk("stable_we", mem_bus.mem_we, stab_we);
          chk("stable_wdata", mem_bus.mem_wdata, stab_wdata);
        end
        stab_pending = !mem_bus.mem_gnt;
        stab_addr    = mem_bus.mem_addr;
        stab_we      = mem_bus.mem_we;
        stab_wdata   = mem_bus.mem_wdata;
      end else begin
        stab_pending = 1'b0;
      end
      if (mem_bus.mem_req && mem_bus.mem_gnt) begin
        chk("sb_access_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          acc_t e;
          e = exp_q.pop_front();
          chk("sb_we", mem_bus.mem_we, e.we);
          chk("sb_addr", mem_bus.mem_addr, e.addr);
          if (e.we) chk("sb_wdata", mem_bus.mem_wdata, e.data);
        end
      end
    end
  end

  // ---------------- expected statistics ----------------
  int unsigned exp_ce = 0, exp_ue = 0;
  bit          exp_ue_seen = 0;
  logic [31:0] exp_ue_first = '0;

  function automatic logic [31:0] exp_uefa();
`ifdef SCRUB_UE_ADDR_LOG_EN
    return exp_ue_first;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_acc(input logic we, input logic [31:0] a);
    acc_t e;
    e.we   = we;
    e.addr = a;
    e.data = data_at(a);
    exp_q.push_back(e);
  endtask

  task automatic run_scan(input logic [31:0] addr, input logic [31:0] size,
                          input int exp_cyc, input int hold, input string name);
    logic [63:0] n;
    logic [31:0] a;
    bit          err = 0;
    bit          seen;
    int          cyc;
    n = ({32'h0, addr & 32'h7} + {32'h0, size} + 64'd7) >> 3;
    a = addr & ~32'h7;
    for (longint i = 0; i < longint'(n); i++) begin
      push_acc(1'b0, a);
      if (ue_at(a)) begin
        err = 1;
        exp_ue++;
        if (!exp_ue_seen) begin
          exp_ue_seen  = 1;
          exp_ue_first = a;
        end
      end else if (ce_at(a)) begin
        exp_ce++;
        push_acc(1'b1, a);
      end
      a = a + 32'd8;
    end
    scrub_addr = addr;
    scrub_size = size;
    scrub_req  = 1'b1;
    @(posedge clk); #1;
    scrub_addr = 32'hDEAD_BEE0;
    scrub_size = 32'h0000_1000;
    cyc  = 1;
    seen = scrub_done;
    while (!seen && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      seen = scrub_done;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (exp_cyc >= 0) chk({name, "_latency"}, cyc, exp_cyc);
    chk({name, "_error"}, scrub_error, err);
    chk({name, "_busy_at_done"}, scrub_busy, 1);
    chk({name, "_ce_count"}, ce_count, exp_ce);
    chk({name, "_ue_count"}, ue_count, exp_ue);
    chk({name, "_ue_first_addr"}, ue_first_addr, exp_uefa());
    for (int h = 0; h < ((hold > 0) ? hold : 1); h++) begin
      @(posedge clk); #1;
      chk({name, "_no_second_done"}, scrub_done, 0);
      chk({name, "_no_rescan"}, mem_bus.mem_req, 0);
      chk({name, "_busy_release"}, scrub_busy, 1);
    end
    scrub_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({name, "_idle_busy"}, scrub_busy, 0);
    chk({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  g;
    int  cyc;
    bit  seen;
    rst        = 1'b1;
    scrub_req  = 1'b0;
    scrub_addr = '0;
    scrub_size = '0;
    gnt_delay  = 0;
    rd_lat     = 1;
    ce_a0 = NONE; ce_a1 = NONE; ue_a0 = NONE; ue_a1 = NONE;
    #1;
    chk("reset_done", scrub_done, 0);
    chk("reset_busy", scrub_busy, 0);
    chk("reset_mem_req", mem_bus.mem_req, 0);
    chk("reset_mem_addr", mem_bus.mem_addr, 0);
    chk("reset_ce_count", ce_count, 0);
    chk("reset_ue_count", ue_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_scan(32'h0000_1000, 32'h40, 25, 0, "clean");

    ce_a0 = 32'h0000_1010;
    run_scan(32'h0000_1000, 32'h20, 14, 0, "ce");

    ce_a0 = 32'h0000_1018;
    ue_a0 = 32'h0000_1010;
    ue_a1 = 32'h0000_1018;
    run_scan(32'h0000_1000, 32'h20, 13, 0, "ue");
    ce_a0 = NONE; ue_a0 = NONE; ue_a1 = NONE;

    run_scan(32'h0000_1000, 32'h0, 1, 0, "size0");
    run_scan(32'h0000_1003, 32'h6, 7, 0, "unaligned");
    run_scan(32'hFFFF_FFF8, 32'h10, 7, 0, "wrap");

    gnt_delay = 5;
    rd_lat    = 3;
    ce_a0     = 32'h0000_2008;
    run_scan(32'h0000_2000, 32'h18, -1, 10, "handshake");
    ce_a0     = NONE;
    gnt_delay = 0;
    rd_lat    = 1;

    // abort after two reads have been granted
    push_acc(1'b0, 32'h0000_4000);
    push_acc(1'b0, 32'h0000_4008);
    scrub_addr = 32'h0000_4000;
    scrub_size = 32'h20;
    scrub_req  = 1'b1;
    g   = 0;
    cyc = 0;
    while (g < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_bus.mem_req && mem_bus.mem_gnt && !mem_bus.mem_we) g++;
    end
    chk("abort_two_reads", g, 2);
    scrub_req = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (scrub_done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_busy", scrub_busy, 0);
    chk("abort_mem_req", mem_bus.mem_req, 0);
    chk("abort_sb_drained", exp_q.size(), 0);

    // reset asserted while waiting for read data
    rd_lat = 3;
    for (int i = 0; i < 4; i++) push_acc(1'b0, 32'h0000_3000 + 32'(i * 8));
    scrub_addr = 32'h0000_3000;
    scrub_size = 32'h20;
    scrub_req  = 1'b1;
    g   = 0;
    cyc = 0;
    while (g < 1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_bus.mem_req && mem_bus.mem_gnt) g++;
    end
    chk("rst_first_grant", g, 1);
    @(posedge clk); #1;
    chk("rst_pre_busy", scrub_busy, 1);
    #2;
    rst       = 1'b1;
    scrub_req = 1'b0;
    #1;
    chk("rst_mid_busy", scrub_busy, 0);
    chk("rst_mid_done", scrub_done, 0);
    chk("rst_mid_error", scrub_error, 0);
    chk("rst_mid_mem_req", mem_bus.mem_req, 0);
    chk("rst_mid_mem_we", mem_bus.mem_we, 0);
    chk("rst_mid_mem_addr", mem_bus.mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_bus.mem_wdata, 0);
    chk("rst_mid_ce_count", ce_count, 0);
    chk("rst_mid_ue_count", ue_count, 0);
    chk("rst_mid_ue_first", ue_first_addr, 0);
    exp_q.delete();
    exp_ce       = 0;
    exp_ue       = 0;
    exp_ue_seen  = 0;
    exp_ue_first = '0;
    rd_lat       = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_scan(32'h0000_5000, 32'h8, 4, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
